mem_arbiter_n: RTL and testbench

- Parametrised N-requester arbiter between the L1 caches/prefetcher and the single L2 / memory-adaptor port.
- Successor to the fixed three-way I/D/prefetch mux:
  - configurable requester count and widths;
  - selectable fixed-priority or round-robin policy;
  - registered downstream request held stable for the whole transaction;
  - explicit turnaround cycle so a requester's stale request is never re-granted.

---
 rtl/mem_arbiter_n.sv | 145 ++++++++++++++
 tb/tb_mem_arbiter_n.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_n.sv
// mem_arbiter_n: N-requester arbiter in front of the single L2 / memory-adaptor port.
// A request wins in IDLE, is registered onto mem_* for the whole transaction (BUSY),
// and is followed by one TURN cycle so the requester can drop its level request
// before the next arbitration.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no owner; arbitrate among pending requesters
// BUSY  | mem_* driven for grant_id; waiting for mem_resp
// TURN  | one-cycle gap after mem_resp; no arbitration
module mem_arbiter_n #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 256,
    parameter int RR_MODE = 0,
    parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_read,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_resp,
    output logic [DATA_W-1:0]         req_rdata,
    output logic                      mem_read,
    output logic                      mem_write,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic                      mem_resp,
    input  logic [DATA_W-1:0]         mem_rdata,
    output logic [ID_W-1:0]           grant_id,
    output logic                      busy
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_TURN} state_t;

    state_t              state_q;
    state_t              state_d;
    logic [NUM_REQ-1:0]  pend;
    logic [ID_W-1:0]     win;
    logic                win_vld;
    logic [ID_W-1:0]     rr_ptr;
    logic [ID_W-1:0]     rr_next;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic                sel_rd;
    logic                sel_wr;

    assign pend = req_read | req_write;
    assign busy = (state_q != S_IDLE);

    // Winner: first pending index at or above rr_ptr, else the lowest pending index.
    // rr_ptr stays 0 in fixed-priority mode, so this reduces to lowest-index-wins.
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!win_vld && pend[i] && (ID_W'(i) >= rr_ptr)) begin
                win_vld = 1'b1;
                win     = ID_W'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!win_vld && pend[i]) begin
                win_vld = 1'b1;
                win     = ID_W'(i);
            end
        end
    end

    // Pointer advance wraps by compare so non-power-of-two NUM_REQ works.
    assign rr_next = (win == ID_W'(NUM_REQ - 1)) ? '0 : win + ID_W'(1);

    // Mux the winning requester's command; write takes precedence over read.
    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_rd    = 1'b0;
        sel_wr    = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win == ID_W'(i)) begin
                sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = req_wdata[i*DATA_W +: DATA_W];
                sel_wr    = req_write[i];
                sel_rd    = req_read[i] & ~req_write[i];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (win_vld) state_d = S_BUSY;
            S_BUSY:  if (mem_resp) state_d = S_TURN;
            S_TURN:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Response path is combinational so the owner sees completion in the mem_resp cycle.
    always_comb begin
        req_resp  = '0;
        req_rdata = '0;
        if (state_q == S_BUSY && mem_resp) begin
            req_rdata = mem_rdata;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant_id == ID_W'(i)) req_resp[i] = 1'b1;
            end
        end
    end

    // Downstream command, owner id and round-robin pointer; held stable through BUSY.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            grant_id  <= '0;
            rr_ptr    <= '0;
        end else if (state_q == S_IDLE && win_vld) begin
            mem_read  <= sel_rd;
            mem_write <= sel_wr;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
            grant_id  <= win;
            if (RR_MODE != 0) rr_ptr <= rr_next;
        end else if (state_q == S_BUSY && mem_resp) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_arbiter_n.sv
// Directed bench for mem_arbiter_n: a fixed-priority 3-way instance, a round-robin
// 3-way instance and a round-robin 5-way / 64-bit-address instance share clock and reset.
module tb_mem_arbiter_n;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // fixed priority, 3 requesters
    logic [2:0]   f_req_read, f_req_write, f_req_resp;
    logic [95:0]  f_req_addr;
    logic [767:0] f_req_wdata;
    logic [255:0] f_req_rdata, f_mem_wdata, f_mem_rdata;
    logic         f_mem_read, f_mem_write, f_mem_resp, f_busy;
    logic [31:0]  f_mem_addr;
    logic [1:0]   f_grant_id;

    // round robin, 3 requesters
    logic [2:0]   r_req_read, r_req_write, r_req_resp;
    logic [95:0]  r_req_addr;
    logic [767:0] r_req_wdata;
    logic [255:0] r_req_rdata, r_mem_wdata, r_mem_rdata;
    logic         r_mem_read, r_mem_write, r_mem_resp, r_busy;
    logic [31:0]  r_mem_addr;
    logic [1:0]   r_grant_id;

    // round robin, 5 requesters, 64-bit address
    logic [4:0]    p_req_read, p_req_write, p_req_resp;
    logic [319:0]  p_req_addr;
    logic [1279:0] p_req_wdata;
    logic [255:0]  p_req_rdata, p_mem_wdata, p_mem_rdata;
    logic          p_mem_read, p_mem_write, p_mem_resp, p_busy;
    logic [63:0]   p_mem_addr;
    logic [2:0]    p_grant_id;

    mem_arbiter_n #(.NUM_REQ(3), .ADDR_W(32), .DATA_W(256), .RR_MODE(0)) dut_fix (
        .clk(clk), .rst(rst),
        .req_read(f_req_read), .req_write(f_req_write), .req_addr(f_req_addr),
        .req_wdata(f_req_wdata), .req_resp(f_req_resp), .req_rdata(f_req_rdata),
        .mem_read(f_mem_read), .mem_write(f_mem_write), .mem_addr(f_mem_addr),
        .mem_wdata(f_mem_wdata), .mem_resp(f_mem_resp), .mem_rdata(f_mem_rdata),
        .grant_id(f_grant_id), .busy(f_busy)
    );

    mem_arbiter_n #(.NUM_REQ(3), .ADDR_W(32), .DATA_W(256), .RR_MODE(1)) dut_rr3 (
        .clk(clk), .rst(rst),
        .req_read(r_req_read), .req_write(r_req_write), .req_addr(r_req_addr),
        .req_wdata(r_req_wdata), .req_resp(r_req_resp), .req_rdata(r_req_rdata),
        .mem_read(r_mem_read), .mem_write(r_mem_write), .mem_addr(r_mem_addr),
        .mem_wdata(r_mem_wdata), .mem_resp(r_mem_resp), .mem_rdata(r_mem_rdata),
        .grant_id(r_grant_id), .busy(r_busy)
    );

    mem_arbiter_n #(.NUM_REQ(5), .ADDR_W(64), .DATA_W(256), .RR_MODE(1)) dut_rr5 (
        .clk(clk), .rst(rst),
        .req_read(p_req_read), .req_write(p_req_write), .req_addr(p_req_addr),
        .req_wdata(p_req_wdata), .req_resp(p_req_resp), .req_rdata(p_req_rdata),
        .mem_read(p_mem_read), .mem_write(p_mem_write), .mem_addr(p_mem_addr),
        .mem_wdata(p_mem_wdata), .mem_resp(p_mem_resp), .mem_rdata(p_mem_rdata),
        .grant_id(p_grant_id), .busy(p_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        n_checks++;
        if (f_busy !== 1'b0 || f_mem_read !== 1'b0 || f_mem_write !== 1'b0 || f_grant_id !== 2'd0
            || f_mem_addr !== 32'd0 || f_req_resp !== 3'b000 || r_busy !== 1'b0 || p_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: busy=%b mem_read=%b mem_write=%b grant=%0d addr=%h resp=%b rbusy=%b pbusy=%b, required all 0",
                     f_busy, f_mem_read, f_mem_write, f_grant_id, f_mem_addr, f_req_resp, r_busy, p_busy);
        end
        rst = 1'b1;
        tick();
        tick();
        f_req_read = 3'b010;
        f_req_addr[32 +: 32] = 32'h2000;
        tick();
        tick();
        n_checks++;
        if (f_mem_read !== 1'b1 || f_grant_id !== 2'd1) begin
            n_fail++;
            $display("FAIL reset_pre_busy: mem_read=%b grant=%0d, required 1 / 1", f_mem_read, f_grant_id);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (f_mem_read !== 1'b0 || f_busy !== 1'b0 || f_grant_id !== 2'd0 || f_mem_addr !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_mid_busy: mem_read=%b busy=%b grant=%0d addr=%h, required 0/0/0/0",
                     f_mem_read, f_busy, f_grant_id, f_mem_addr);
        end
        f_req_read = 3'b000;
        tick();
        rst = 1'b1;
        tick();
        tick();
        f_mem_resp  = 1'b1;
        f_mem_rdata = 256'hDEAD;
        #1;
        n_checks++;
        if (f_req_resp !== 3'b000 || f_req_rdata !== 256'd0 || f_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_late_resp: resp=%b rdata=%h busy=%b, required 000 / 0 / 0", f_req_resp, f_req_rdata, f_busy);
        end
        tick();
        f_mem_resp  = 1'b0;
        f_mem_rdata = '0;
    endtask

    task automatic test_single_read();
        tick();
        f_req_read = 3'b001;
        f_req_addr[0 +: 32] = 32'h0000_1000;
        tick();
        n_checks++;
        if (f_mem_read !== 1'b1 || f_mem_write !== 1'b0 || f_mem_addr !== 32'h1000 || f_grant_id !== 2'd0 || f_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_issue: mem_read=%b mem_write=%b addr=%h grant=%0d busy=%b, required 1/0/1000/0/1",
                     f_mem_read, f_mem_write, f_mem_addr, f_grant_id, f_busy);
        end
        tick();
        tick();
        n_checks++;
        if (f_req_resp !== 3'b000 || f_mem_read !== 1'b1) begin
            n_fail++;
            $display("FAIL single_wait: resp=%b mem_read=%b, required 000 / 1", f_req_resp, f_mem_read);
        end
        tick();
        f_mem_resp  = 1'b1;
        f_mem_rdata = 256'hA5;
        #1;
        n_checks++;
        if (f_req_resp !== 3'b001 || f_req_rdata !== 256'hA5) begin
            n_fail++;
            $display("FAIL single_resp: resp=%b rdata=%h, required 001 / a5", f_req_resp, f_req_rdata);
        end
        tick();
        f_mem_resp  = 1'b0;
        f_req_read  = 3'b000;
        #1;
        n_checks++;
        if (f_busy !== 1'b1 || f_mem_read !== 1'b0 || f_req_resp !== 3'b000 || f_req_rdata !== 256'd0) begin
            n_fail++;
            $display("FAIL single_turn: busy=%b mem_read=%b resp=%b rdata=%h, required 1/0/000/0",
                     f_busy, f_mem_read, f_req_resp, f_req_rdata);
        end
        tick();
        n_checks++;
        if (f_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_idle: busy=%b, required 0", f_busy);
        end
    endtask

    task automatic test_fixed_priority();
        f_req_read = 3'b111;
        for (int k = 0; k < 3; k++) begin
            for (int t = 0; t < 20 && !(f_busy && f_mem_read); t++) tick();
            n_checks++;
            if (!(f_busy && f_mem_read)) begin
                n_fail++;
                $display("FAIL fixed_wait_%0d: busy=%b mem_read=%b, required grant within 20 cycles", k, f_busy, f_mem_read);
            end
            n_checks++;
            if (f_grant_id !== 2'(k)) begin
                n_fail++;
                $display("FAIL fixed_grant_%0d: grant=%0d, required %0d", k, f_grant_id, k);
            end
            f_mem_resp = 1'b1;
            #1;
            n_checks++;
            if (f_req_resp !== 3'(1 << k)) begin
                n_fail++;
                $display("FAIL fixed_resp_%0d: resp=%b, required %b", k, f_req_resp, 3'(1 << k));
            end
            tick();
            f_mem_resp = 1'b0;
            f_req_read[k] = 1'b0;
        end
        tick();
    endtask

    task automatic test_write_conflict();
        f_req_read[1]         = 1'b1;
        f_req_write[1]        = 1'b1;
        f_req_addr[32 +: 32]  = 32'h40;
        f_req_wdata[256 +: 256] = 256'h1;
        for (int t = 0; t < 20 && !(f_busy && f_mem_write); t++) tick();
        n_checks++;
        if (f_mem_write !== 1'b1 || f_mem_read !== 1'b0 || f_mem_wdata !== 256'h1 || f_mem_addr !== 32'h40 || f_grant_id !== 2'd1) begin
            n_fail++;
            $display("FAIL wr_conflict: mem_write=%b mem_read=%b wdata=%h addr=%h grant=%0d, required 1/0/1/40/1",
                     f_mem_write, f_mem_read, f_mem_wdata, f_mem_addr, f_grant_id);
        end
        f_req_addr[32 +: 32]    = 32'h80;
        f_req_wdata[256 +: 256] = 256'h2;
        f_req_read[0]           = 1'b1;
        tick();
        tick();
        n_checks++;
        if (f_mem_addr !== 32'h40 || f_mem_wdata !== 256'h1 || f_mem_write !== 1'b1 || f_grant_id !== 2'd1) begin
            n_fail++;
            $display("FAIL wr_hold: addr=%h wdata=%h mem_write=%b grant=%0d, required 40/1/1/1",
                     f_mem_addr, f_mem_wdata, f_mem_write, f_grant_id);
        end
        f_mem_resp  = 1'b1;
        f_mem_rdata = 256'h77;
        #1;
        n_checks++;
        if (f_req_resp !== 3'b010 || f_req_rdata !== 256'h77) begin
            n_fail++;
            $display("FAIL wr_resp: resp=%b rdata=%h, required 010 / 77", f_req_resp, f_req_rdata);
        end
        tick();
        f_mem_resp  = 1'b0;
        f_req_read  = 3'b000;
        f_req_write = 3'b000;
        n_checks++;
        if (f_mem_write !== 1'b0 || f_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL wr_turn: mem_write=%b busy=%b, required 0 / 1", f_mem_write, f_busy);
        end
        tick();
        tick();
    endtask

    task automatic test_spurious_resp();
        f_mem_resp  = 1'b1;
        f_mem_rdata = 256'hFF;
        #1;
        n_checks++;
        if (f_req_resp !== 3'b000 || f_req_rdata !== 256'd0 || f_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL spurious_resp: resp=%b rdata=%h busy=%b, required 000 / 0 / 0", f_req_resp, f_req_rdata, f_busy);
        end
        tick();
        f_mem_resp = 1'b0;
        n_checks++;
        if (f_busy !== 1'b0 || f_grant_id !== 2'd1) begin
            n_fail++;
            $display("FAIL spurious_hold: busy=%b grant=%0d, required 0 / 1", f_busy, f_grant_id);
        end
    endtask

    task automatic test_round_robin3();
        int waits [3];
        for (int j = 0; j < 3; j++) waits[j] = 0;
        for (int j = 0; j < 3; j++) r_req_wdata[j*256 +: 256] = 256'(j + 16);
        r_req_read = 3'b111;
        for (int k = 0; k < 6; k++) begin
            int g;
            for (int t = 0; t < 20 && !(r_busy && r_mem_read); t++) tick();
            n_checks++;
            if (!(r_busy && r_mem_read)) begin
                n_fail++;
                $display("FAIL rr3_wait_%0d: busy=%b mem_read=%b, required grant within 20 cycles", k, r_busy, r_mem_read);
            end
            n_checks++;
            if (r_grant_id !== 2'(k % 3) || r_mem_wdata !== 256'((k % 3) + 16)) begin
                n_fail++;
                $display("FAIL rr3_grant_%0d: grant=%0d wdata=%h, required %0d / %h", k, r_grant_id, r_mem_wdata, k % 3, (k % 3) + 16);
            end
            g = int'(r_grant_id);
            for (int j = 0; j < 3; j++) begin
                if (j == g) waits[j] = 0;
                else waits[j]++;
                n_checks++;
                if (waits[j] > 2) begin
                    n_fail++;
                    $display("FAIL rr3_fair_%0d_req%0d: waited %0d transactions, required at most 2", k, j, waits[j]);
                end
            end
            r_mem_resp  = 1'b1;
            r_mem_rdata = 256'(k + 100);
            #1;
            n_checks++;
            if (r_req_resp !== 3'(1 << (k % 3)) || r_req_rdata !== 256'(k + 100)) begin
                n_fail++;
                $display("FAIL rr3_resp_%0d: resp=%b rdata=%h, required %b / %h", k, r_req_resp, r_req_rdata, 3'(1 << (k % 3)), k + 100);
            end
            tick();
            r_mem_resp = 1'b0;
            r_req_read[g[1:0]] = 1'b0;
            tick();
            r_req_read = (k == 5) ? 3'b000 : 3'b111;
        end
    endtask

    task automatic rr5_step(input int exp_id, input logic [4:0] next_pend);
        for (int t = 0; t < 20 && !(p_busy && p_mem_read); t++) tick();
        n_checks++;
        if (!(p_busy && p_mem_read)) begin
            n_fail++;
            $display("FAIL rr5_wait_%0d: busy=%b mem_read=%b, required grant within 20 cycles", exp_id, p_busy, p_mem_read);
        end
        n_checks++;
        if (p_grant_id !== 3'(exp_id) || p_mem_addr !== (64'hF000_0000_0000_0000 | 64'(exp_id))
            || p_mem_wdata !== 256'(exp_id + 1) || p_mem_write !== 1'b0) begin
            n_fail++;
            $display("FAIL rr5_grant: grant=%0d addr=%h wdata=%h mem_write=%b, required %0d / f0..%0d / %0d / 0",
                     p_grant_id, p_mem_addr, p_mem_wdata, p_mem_write, exp_id, exp_id, exp_id + 1);
        end
        p_mem_resp  = 1'b1;
        p_mem_rdata = 256'(exp_id + 200);
        #1;
        n_checks++;
        if (p_req_resp !== 5'(1 << exp_id) || p_req_rdata !== 256'(exp_id + 200)) begin
            n_fail++;
            $display("FAIL rr5_resp_%0d: resp=%b rdata=%h, required %b / %h", exp_id, p_req_resp, p_req_rdata, 5'(1 << exp_id), exp_id + 200);
        end
        tick();
        p_mem_resp = 1'b0;
        p_req_read[exp_id] = 1'b0;
        tick();
        p_req_read = next_pend;
    endtask

    task automatic test_round_robin5();
        for (int j = 0; j < 5; j++) begin
            p_req_addr[j*64 +: 64]   = 64'hF000_0000_0000_0000 | 64'(j);
            p_req_wdata[j*256 +: 256] = 256'(j + 1);
        end
        p_req_read = 5'b11111;
        for (int k = 0; k < 5; k++) rr5_step(k, 5'b11111);
        // after the wrap from 4 to 0 the pointer sits at 1; only 0 and 3 pending -> 3
        rr5_step(0, 5'b01001);
        // pointer now 4; 0 and 2 pending -> scan wraps past 4 to 0
        rr5_step(3, 5'b00101);
        rr5_step(0, 5'b00100);
        rr5_step(2, 5'b00000);
    endtask

    initial begin
        f_req_read = '0; f_req_write = '0; f_req_addr = '0; f_req_wdata = '0;
        f_mem_resp = 1'b0; f_mem_rdata = '0;
        r_req_read = '0; r_req_write = '0; r_req_addr = '0; r_req_wdata = '0;
        r_mem_resp = 1'b0; r_mem_rdata = '0;
        p_req_read = '0; p_req_write = '0; p_req_addr = '0; p_req_wdata = '0;
        p_mem_resp = 1'b0; p_mem_rdata = '0;
        #3;
        test_reset();
        test_single_read();
        test_fixed_priority();
        test_write_conflict();
        test_spurious_resp();
        test_round_robin3();
        test_round_robin5();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
